bomberman_draw_control: RTL and testbench

Sequencing FSM for `bomberman_datapath`. It draws the stage background once after reset, then redraws the 11×11 tile grid and both player sprites every frame. It issues one `copy` job at a time and waits for the `finished` handshake between jobs. A frame divider gates redraws and generates the `refresh` pulse that clocks the player coordinate counters.

---
 rtl/bomberman_pkg.sv | 109 ++++++++++
 rtl/frame_tick_gen.sv | 28 ++
 rtl/bomberman_draw_control.sv | 124 ++++++++++++
 tb/tb_bomberman_draw_control.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared types and constants for the bomberman draw controller.
package bomberman_pkg;

  // Sprite source selects driven on memory_select.
  localparam logic [1:0] MEM_STAGE = 2'd0;
  localparam logic [1:0] MEM_TILE  = 2'd1;
  localparam logic [1:0] MEM_P1    = 2'd2;
  localparam logic [1:0] MEM_P2    = 2'd3;

  // Tiles per side of the square play field.
  localparam int unsigned GRID_N = 11;

  typedef enum logic [3:0] {
    StInit,
    StStageGo,
    StStageWait,
    StTSetup,
    StTGo,
    StTWait,
    StTNext,
    StTCheck,
    StP1Setup,
    StP1Go,
    StP1Wait,
    StP2Setup,
    StP2Go,
    StP2Wait,
    StFrameWait,
    StRefresh
  } draw_state_e;

  // Per-state control outputs, registered as a group in the top.
  typedef struct packed {
    logic [1:0] memory_select;
    logic       copy_enable;
    logic       tc_enable;
    logic       draw_stage;
    logic       draw_t;
    logic       draw_p1;
    logic       draw_p2;
    logic       player_reset;
    logic       stage_reset;
    logic       refresh;
  } draw_out_t;

  function automatic logic is_go_state(draw_state_e st);
    return st inside {StStageGo, StTGo, StP1Go, StP2Go};
  endfunction

  function automatic logic is_wait_state(draw_state_e st);
    return st inside {StStageWait, StTWait, StP1Wait, StP2Wait};
  endfunction

  // Output decode for a state; selects hold through setup, go and wait so the
  // datapath base coordinates stay stable for the whole copy.
  function automatic draw_out_t decode_outputs(draw_state_e st);
    draw_out_t o;
    o = '0;
    unique case (st)
      StInit: begin
        o.player_reset = 1'b1;
        o.stage_reset  = 1'b1;
      end
      StStageGo: begin
        o.draw_stage    = 1'b1;
        o.memory_select = MEM_STAGE;
        o.copy_enable   = 1'b1;
      end
      StStageWait: begin
        o.draw_stage    = 1'b1;
        o.memory_select = MEM_STAGE;
      end
      StTSetup, StTWait: begin
        o.draw_t        = 1'b1;
        o.memory_select = MEM_TILE;
      end
      StTGo: begin
        o.draw_t        = 1'b1;
        o.memory_select = MEM_TILE;
        o.copy_enable   = 1'b1;
      end
      StTNext: o.tc_enable = 1'b1;
      StTCheck: ;
      StP1Setup, StP1Wait: begin
        o.draw_p1       = 1'b1;
        o.memory_select = MEM_P1;
      end
      StP1Go: begin
        o.draw_p1       = 1'b1;
        o.memory_select = MEM_P1;
        o.copy_enable   = 1'b1;
      end
      StP2Setup, StP2Wait: begin
        o.draw_p2       = 1'b1;
        o.memory_select = MEM_P2;
      end
      StP2Go: begin
        o.draw_p2       = 1'b1;
        o.memory_select = MEM_P2;
        o.copy_enable   = 1'b1;
      end
      StFrameWait: ;
      StRefresh: o.refresh = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one-cycle tick every FRAME_DIV clocks.
module frame_tick_gen #(
  parameter int unsigned FRAME_DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] count_q;

  // Count 0..FRAME_DIV-1 and wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/bomberman_draw_control.sv
// Draw sequencer: stage once after reset, then 121 tiles, P1 and P2 every frame.
module bomberman_draw_control
  import bomberman_pkg::*;
#(
  parameter int unsigned FRAME_DIV  = 833333,
  parameter int unsigned WAIT_LIMIT = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       finished,
  input  logic       all_tiles_drawn,
  output logic [1:0] memory_select,
  output logic       copy_enable,
  output logic       tc_enable,
  output logic       draw_stage,
  output logic       draw_t,
  output logic       draw_p1,
  output logic       draw_p2,
  output logic       player_reset,
  output logic       stage_reset,
  output logic       refresh,
  output logic       frame_overrun,
  output logic       timeout_err
);

  localparam int unsigned WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_LIMIT);

  draw_state_e   state_q, state_d;
  draw_out_t     out_q;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          tick_pending_q;
  logic          frame_tick;
  logic          wait_expired;
  logic          job_done;

  frame_tick_gen #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_tick_gen (
    .clock (clock),
    .reset (reset),
    .tick  (frame_tick)
  );

  // Next-state logic; a wait that runs out behaves exactly like a finish.
  always_comb begin
    wait_expired = (wait_cnt_q == WAIT_MAX);
    job_done     = finished || wait_expired;
    state_d      = state_q;
    unique case (state_q)
      StInit:      state_d = StStageGo;
      StStageGo:   state_d = StStageWait;
      StStageWait: if (job_done) state_d = StTSetup;
      StTSetup:    state_d = StTGo;
      StTGo:       state_d = StTWait;
      StTWait:     if (job_done) state_d = StTNext;
      StTNext:     state_d = StTCheck;
      // Tile counters have already advanced here; all zero means they wrapped.
      StTCheck:    state_d = all_tiles_drawn ? StP1Setup : StTSetup;
      StP1Setup:   state_d = StP1Go;
      StP1Go:      state_d = StP1Wait;
      StP1Wait:    if (job_done) state_d = StP2Setup;
      StP2Setup:   state_d = StP2Go;
      StP2Go:      state_d = StP2Wait;
      StP2Wait:    if (job_done) state_d = StFrameWait;
      StFrameWait: if (tick_pending_q) state_d = StRefresh;
      StRefresh:   state_d = StTSetup;
      default:     state_d = StInit;
    endcase
  end

  // Wait counter: zero in each GO cycle, counts through GO and WAIT, saturates.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (is_go_state(state_d)) begin
      wait_cnt_d = '0;
    end else if ((is_go_state(state_q) || is_wait_state(state_q)) && !wait_expired) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end
  end

  // FSM state register with outputs decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StInit;
      out_q   <= decode_outputs(StInit);
    end else begin
      state_q <= state_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  // Wait counter, pending frame tick and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q     <= '0;
      tick_pending_q <= 1'b0;
      frame_overrun  <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      // A new tick wins over the REFRESH clear so no frame is lost.
      if (frame_tick) begin
        tick_pending_q <= 1'b1;
      end else if (state_q == StRefresh) begin
        tick_pending_q <= 1'b0;
      end
      if (frame_tick && tick_pending_q) frame_overrun <= 1'b1;
      if (is_wait_state(state_q) && wait_expired && !finished) timeout_err <= 1'b1;
    end
  end

  assign memory_select = out_q.memory_select;
  assign copy_enable   = out_q.copy_enable;
  assign tc_enable     = out_q.tc_enable;
  assign draw_stage    = out_q.draw_stage;
  assign draw_t        = out_q.draw_t;
  assign draw_p1       = out_q.draw_p1;
  assign draw_p2       = out_q.draw_p2;
  assign player_reset  = out_q.player_reset;
  assign stage_reset   = out_q.stage_reset;
  assign refresh       = out_q.refresh;

endmodule

// File: tb/tb_bomberman_draw_control.sv
// Self-checking bench: job-level reference model plus reactive copy engine.
module tb_bomberman_draw_control;

  localparam int FRAME_DIV  = 64;
  localparam int WAIT_LIMIT = 16;
  localparam int GRID       = 11;
  localparam int TILES      = GRID * GRID;
  localparam int FIN_DELAY  = 3;

  localparam int J_INIT = 0, J_STAGE = 1, J_TILE = 2, J_P1 = 3, J_P2 = 4;
  localparam int J_FWAIT = 5, J_REFRESH = 6;

  typedef struct packed {
    logic [1:0] mem;
    logic copy, tc, ds, dt, d1, d2, pr, sr, rf, ov, to;
  } outv_t;

  logic       clock = 1'b0;
  logic       reset, finished, all_tiles_drawn;
  logic [1:0] memory_select;
  logic       copy_enable, tc_enable, draw_stage, draw_t, draw_p1, draw_p2;
  logic       player_reset, stage_reset, refresh, frame_overrun, timeout_err;

  bomberman_draw_control #(
    .FRAME_DIV  (FRAME_DIV),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .finished        (finished),
    .all_tiles_drawn (all_tiles_drawn),
    .memory_select   (memory_select),
    .copy_enable     (copy_enable),
    .tc_enable       (tc_enable),
    .draw_stage      (draw_stage),
    .draw_t          (draw_t),
    .draw_p1         (draw_p1),
    .draw_p2         (draw_p2),
    .player_reset    (player_reset),
    .stage_reset     (stage_reset),
    .refresh         (refresh),
    .frame_overrun   (frame_overrun),
    .timeout_err     (timeout_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0, cyc = 0;

  // Reference model: current job, cycle within job and frame-tick bookkeeping.
  int m_job = J_INIT, m_step = 0, m_wait = FIN_DELAY, m_tile = 0, m_jobs = 0, m_edges = 0;
  bit m_sup = 0, m_pending = 0, m_ov = 0, m_to = 0, m_valid = 0;
  outv_t m_exp = '0;

  // Environment: copy engine, datapath tile counters, stimulus choices.
  int fin_cnt = 0, n_copy = 0, tx = 0, ty = 0, n_stray = 0;
  int sup_job = -1, rst_tile = 40;
  bit tc_seen = 0;

  // Observed frame statistics.
  int rf_count = 0, last_rf = -1, tc_frame = 0;
  int tc_rec[8], sp_rec[8];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic outv_t dut_vec();
    outv_t v;
    v.mem = memory_select; v.copy = copy_enable; v.tc = tc_enable;
    v.ds = draw_stage; v.dt = draw_t; v.d1 = draw_p1; v.d2 = draw_p2;
    v.pr = player_reset; v.sr = stage_reset; v.rf = refresh;
    v.ov = frame_overrun; v.to = timeout_err;
    return v;
  endfunction

  function automatic int go_step(int job);
    return (job == J_STAGE) ? 0 : 1;
  endfunction

  // Stage: GO + waits. Players: SETUP, GO, waits. Tiles add NEXT and CHECK.
  function automatic int job_len(int job, int w);
    if (job == J_STAGE) return 1 + w;
    if (job == J_TILE) return 4 + w;
    return 2 + w;
  endfunction

  function automatic void start_job(int job);
    m_job  = job;
    m_step = 0;
    m_sup  = (m_jobs == sup_job);
    m_wait = m_sup ? WAIT_LIMIT : FIN_DELAY;
    m_jobs++;
  endfunction

  function automatic outv_t model_outputs();
    outv_t o;
    int g;
    o = '0;
    g = go_step(m_job);
    case (m_job)
      J_INIT: begin o.pr = 1; o.sr = 1; end
      J_STAGE: begin o.ds = 1; o.copy = (m_step == 0); end
      J_TILE, J_P1, J_P2: begin
        if (m_step <= g + m_wait) begin
          o.mem  = 2'(m_job - 1);
          o.copy = (m_step == g);
          o.dt   = (m_job == J_TILE);
          o.d1   = (m_job == J_P1);
          o.d2   = (m_job == J_P2);
        end else if (m_step == g + m_wait + 1) begin
          o.tc = 1;
        end
      end
      J_REFRESH: o.rf = 1;
      default: ;
    endcase
    o.ov = m_ov;
    o.to = m_to;
    return o;
  endfunction

  function automatic void model_edge(logic rst);
    int prev_job;
    bit tick, old_pending;
    if (rst) begin
      m_valid = 1; m_job = J_INIT; m_step = 0; m_edges = 0;
      m_pending = 0; m_ov = 0; m_to = 0; m_jobs = 0; m_tile = 0;
    end else if (m_valid) begin
      prev_job    = m_job;
      old_pending = m_pending;
      m_edges++;
      tick = (m_edges % FRAME_DIV == 0);
      case (m_job)
        J_INIT:    start_job(J_STAGE);
        J_FWAIT:   if (old_pending) begin m_job = J_REFRESH; m_step = 0; end
        J_REFRESH: begin m_tile = 0; start_job(J_TILE); end
        default: begin
          if (m_sup && m_step == go_step(m_job) + m_wait) m_to = 1;
          m_step++;
          if (m_step == job_len(m_job, m_wait)) begin
            case (m_job)
              J_STAGE: begin m_tile = 0; start_job(J_TILE); end
              J_TILE: begin
                m_tile++;
                if (m_tile == TILES) start_job(J_P1);
                else start_job(J_TILE);
              end
              J_P1:    start_job(J_P2);
              default: begin m_job = J_FWAIT; m_step = 0; end
            endcase
          end
        end
      endcase
      if (tick) begin
        if (old_pending) m_ov = 1;
        m_pending = 1;
      end else if (prev_job == J_REFRESH) begin
        m_pending = 0;
      end
    end
    m_exp = model_outputs();
  endfunction

  // One clock: advance model, then drive copy engine and tile counters.
  task automatic step();
    logic rst_edge;
    @(posedge clock);
    rst_edge = reset;
    model_edge(rst_edge);
    #1;
    if (rst_edge) begin
      fin_cnt = 0; n_copy = 0; tx = 0; ty = 0; finished = 1'b0;
    end else begin
      if (tc_seen) begin
        tx++;
        if (tx == GRID) begin
          tx = 0; ty++;
          if (ty == GRID) ty = 0;
        end
      end
      finished = 1'b0;
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) finished = 1'b1;
      end
      // Stray pulse while the model says T_SETUP; the controller must ignore it.
      if (!finished && m_job == J_TILE && m_step == 0 && $urandom_range(0, 3) == 0) begin
        finished = 1'b1;
        n_stray++;
      end
    end
    all_tiles_drawn = (tx == 0 && ty == 0);
    tc_seen = tc_enable;
    if (!rst_edge && copy_enable === 1'b1) begin
      if (n_copy != sup_job) fin_cnt = FIN_DELAY;
      n_copy++;
    end
  endtask

  task automatic run_until(int target, int budget);
    int n;
    n = 0;
    while (rf_count < target && n < budget) begin
      step();
      n++;
    end
    if (rf_count < target) check("refresh_wait_budget", rf_count, target);
  endtask

  // Per-cycle comparison against the model and frame statistics.
  always @(negedge clock) begin
    cyc++;
    if (m_valid) check("outputs", {19'd0, dut_vec()}, {19'd0, m_exp});
    if (reset) begin
      last_rf  = -1;
      tc_frame = 0;
    end else if (m_valid) begin
      if (tc_enable === 1'b1) tc_frame++;
      if (refresh === 1'b1 && rf_count < 8) begin
        tc_rec[rf_count] = tc_frame;
        sp_rec[rf_count] = (last_rf >= 0) ? cyc - last_rf : -1;
        last_rf  = cyc;
        tc_frame = 0;
        rf_count++;
      end
    end
  end

  initial begin
    outv_t init_v, go_v;
    int n;
    init_v = '0; init_v.pr = 1; init_v.sr = 1;
    go_v = '0; go_v.ds = 1; go_v.copy = 1;
    reset = 1'b1; finished = 1'b0; all_tiles_drawn = 1'b1;
    sup_job  = TILES + 3 + $urandom_range(2, 10);
    rst_tile = $urandom_range(36, 44);

    step(); step();
    check("reset_outputs", {19'd0, dut_vec()}, {19'd0, init_v});
    reset = 1'b0;
    step();
    check("first_stage_go", {19'd0, dut_vec()}, {19'd0, go_v});

    run_until(3, 4000);
    check("frame0_tc_count", tc_rec[0], TILES);
    check("frame1_tc_count", tc_rec[1], TILES);
    check("frame2_tc_count", tc_rec[2], TILES);
    // 121*7 + 2*5 draw cycles, plus FRAME_WAIT and REFRESH; +13 with one timeout.
    check("frame1_spacing_timeout", sp_rec[1], 872);
    check("frame2_spacing", sp_rec[2], 859);
    check("timeout_sticky", timeout_err, 1);
    check("overrun_sticky", frame_overrun, 1);

    n = 0;
    while (!(m_job == J_TILE && m_tile == rst_tile && m_step == 2) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) check("reset_arm_budget", n, 0);
    reset   = 1'b1;
    sup_job = -1;
    step();
    check("mid_reset_outputs", {19'd0, dut_vec()}, {19'd0, init_v});
    reset = 1'b0;
    step();
    check("restart_stage_go", {19'd0, dut_vec()}, {19'd0, go_v});

    run_until(5, 4000);
    check("post_reset_tc_count", tc_rec[3], TILES);
    check("post_reset_tc_count2", tc_rec[4], TILES);
    check("post_reset_spacing", sp_rec[4], 859);
    check("post_reset_no_timeout", timeout_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
